lcd_msg_scheduler: RTL and testbench
====================================

LCD_MSG_SCHEDULER -- requirements
Module: lcd_msg_scheduler

Interface
REQ-001 Parameter CLR_BYTE, default 8'h01: LCD clear/home command byte sent before every message.
REQ-002 Parameter SKIP_REPEAT, default 1: when 1, a granted message equal to cur_msg is not re-streamed.
REQ-003 clk  input  1  single clock for the whole block; all state changes on its rising edge.
REQ-004 rstb  input  1  asynchronous, active-high reset (port name rstb; polarity and synchronicity fixed).
REQ-005 req_a  input  1  request from state controller; held high until gnt_a seen.
REQ-006 msg_a  input  3  message code for requester A; stable while req_a high.
REQ-007 req_b  input  1  request from voice-command classifier; held high until gnt_b seen.
REQ-008 msg_b  input  3  message code for requester B; stable while req_b high.
REQ-009 gnt_a / gnt_b  output  1 each  one-cycle grant pulses.
REQ-010 rom_addr  output  7  {msg[2:0], idx[3:0]} into external 128x8 message ROM.
REQ-011 rom_data  input  8  ROM byte; combinational function of rom_addr (async read).
REQ-012 char_out  output  8  byte toward lcd_driver char_in.
REQ-013 char_valid  output  1  char_out valid toward lcd_driver.
REQ-014 char_is_cmd  output  1  high while char_out is CLR_BYTE (command, not data).
REQ-015 char_ready  input  1  lcd_driver accepts the byte.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 done  output  1  one-cycle pulse at end of each granted message.
REQ-018 cur_msg  output  3  code of the most recently granted message.

Function
REQ-019 States: IDLE, CLEAR, STREAM, DONE; state register, idx[3:0], msg latch, last_grant, cur_msg all registered.
REQ-020 IDLE with any request at rising edge -> grant registered: gnt_x high for exactly the next cycle, msg latched, cur_msg updated, last_grant updated.
REQ-021 Arbitration: only one requester -> grant it; both -> grant the one not equal to last_grant (round-robin).
REQ-022 After grant: if SKIP_REPEAT=1 and latched msg equals cur_msg value held before the grant -> go to DONE (no char_valid); otherwise -> CLEAR.
REQ-023 CLEAR: char_valid=1, char_is_cmd=1, char_out=CLR_BYTE; on char_valid&&char_ready -> STREAM with idx=0.
REQ-024 STREAM: rom_addr={msg,idx}, char_out=rom_data, char_valid=1, char_is_cmd=0.
REQ-025 STREAM transfer (char_valid&&char_ready) with idx<15 -> idx+1; with idx=15 -> DONE; idx never wraps within a message.
REQ-026 char_ready low -> state, idx, rom_addr and char_out held unchanged; no transfer lost or duplicated.
REQ-027 DONE lasts exactly one cycle with done=1, then IDLE; char_valid=0 in IDLE and DONE.
REQ-028 Requests arriving while busy are not granted until the next IDLE cycle; no request is ever dropped.
REQ-029 gnt_a and gnt_b are never high in the same cycle; at most one grant per message.
REQ-030 Minimum message latency with char_ready=1: grant edge to done pulse = 1 (CLEAR) + 16 (STREAM) + 1 (DONE) = 18 cycles.

Reset
REQ-031 rstb high asynchronously forces: state=IDLE, idx=0, msg=0, cur_msg=0, last_grant=B, all outputs 0 (rom_addr=0, char_out=0).
REQ-032 Reset mid-message aborts it immediately; no further bytes after rstb deasserts; a pending request after deassert is arbitrated afresh.

Verification
REQ-033 Reset, req_a=1 msg_a=3, char_ready=1 -> gnt_a 1 cycle; CLR_BYTE with char_is_cmd=1; rom_addr 0x30..0x3F on 16 consecutive cycles; done 18 cycles after grant; cur_msg=3.
REQ-034 Reset, req_a=req_b=1 (msg 1, msg 2) -> gnt_a first, message 1 streamed; gnt_b in first IDLE after done; never both grants together.
REQ-035 Stream msg 5, drop char_ready for 5 cycles while idx=7 -> rom_addr 0x57 and char_out stable all 5 cycles; idx 8 only after ready returns.
REQ-036 SKIP_REPEAT=1, cur_msg=4, req_b msg_b=4 -> gnt_b pulse, done next cycle, char_valid never high.
REQ-037 Assert rstb during STREAM idx=9 -> char_valid, busy, cur_msg 0 in same cycle without clock edge; after deassert with no request, block stays IDLE.

Source files
------------

// File: rtl/lcd_msg_scheduler.sv
// Arbitrates two message requesters and streams the granted message to the LCD driver:
// a clear/home command byte, then 16 ROM bytes, then a one-cycle done pulse.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a request; the grant is registered on this edge
// S_CLEAR  | presenting CLR_BYTE as a command byte
// S_STREAM | presenting ROM byte {msg, idx}, idx 0..15
// S_DONE   | one-cycle end-of-message pulse
module lcd_msg_scheduler #(
    parameter logic [7:0] CLR_BYTE    = 8'h01,
    parameter bit         SKIP_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       req_a,
    input  logic [2:0] msg_a,
    input  logic       req_b,
    input  logic [2:0] msg_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic [6:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] char_out,
    output logic       char_valid,
    output logic       char_is_cmd,
    input  logic       char_ready,
    output logic       busy,
    output logic       done,
    output logic [2:0] cur_msg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] IDX_LAST = 4'd15;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_idx;
    logic [2:0] r_msg;
    logic [2:0] r_cur_msg;
    logic       r_last_b;
    logic       r_gnt_a;
    logic       r_gnt_b;

    logic       w_any_req;
    logic       w_pick_b;
    logic [2:0] w_sel_msg;
    logic       w_skip;
    logic       w_xfer;

    // With both requesters active, the one not granted last time wins.
    assign w_any_req = req_a | req_b;
    assign w_pick_b  = req_b & (~req_a | ~r_last_b);
    assign w_sel_msg = w_pick_b ? msg_b : msg_a;
    assign w_skip    = SKIP_REPEAT && (w_sel_msg == r_cur_msg);
    assign w_xfer    = char_valid & char_ready;

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = w_skip ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (w_xfer) begin
                    w_next_state = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_xfer && (r_idx == IDX_LAST)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        char_valid  = 1'b0;
        char_is_cmd = 1'b0;
        char_out    = 8'h00;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_CLEAR: begin
                char_valid  = 1'b1;
                char_is_cmd = 1'b1;
                char_out    = CLR_BYTE;
            end
            S_STREAM: begin
                char_valid = 1'b1;
                char_out   = rom_data;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Grant, message latch and arbitration history all update on the IDLE grant edge.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            r_gnt_a   <= 1'b0;
            r_gnt_b   <= 1'b0;
            r_msg     <= 3'd0;
            r_cur_msg <= 3'd0;
            r_last_b  <= 1'b1;
        end else begin
            r_gnt_a <= 1'b0;
            r_gnt_b <= 1'b0;
            if ((r_state == S_IDLE) && w_any_req) begin
                r_gnt_a   <= ~w_pick_b;
                r_gnt_b   <= w_pick_b;
                r_msg     <= w_sel_msg;
                r_cur_msg <= w_sel_msg;
                r_last_b  <= w_pick_b;
            end
        end
    end

    // idx holds at 15 on the final transfer; it is cleared when the clear byte is accepted.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            r_idx <= 4'd0;
        end else if (w_xfer) begin
            if (r_state == S_CLEAR) begin
                r_idx <= 4'd0;
            end else if (r_idx != IDX_LAST) begin
                r_idx <= r_idx + 4'd1;
            end
        end
    end

    assign gnt_a    = r_gnt_a;
    assign gnt_b    = r_gnt_b;
    assign cur_msg  = r_cur_msg;
    assign rom_addr = {r_msg, r_idx};

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Self-checking bench for lcd_msg_scheduler: a queue-based transaction model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_lcd_msg_scheduler;

    logic       clk = 1'b0;
    logic       rstb;
    logic       req_a, req_b;
    logic [2:0] msg_a, msg_b;
    logic       gnt_a, gnt_b;
    logic [6:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] char_out;
    logic       char_valid, char_is_cmd, char_ready;
    logic       busy, done;
    logic [2:0] cur_msg;

    logic [7:0] rom_mem [128];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    assign rom_data = rom_mem[rom_addr];

    lcd_msg_scheduler #(.CLR_BYTE(8'h01), .SKIP_REPEAT(1'b1)) dut (
        .clk(clk), .rstb(rstb),
        .req_a(req_a), .msg_a(msg_a), .req_b(req_b), .msg_b(msg_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .char_out(char_out), .char_valid(char_valid), .char_is_cmd(char_is_cmd),
        .char_ready(char_ready),
        .busy(busy), .done(done), .cur_msg(cur_msg)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Requesters drop their request once they have seen their grant.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (gnt_a) req_a = 1'b0;
        if (gnt_b) req_b = 1'b0;
    endtask

    task automatic wait_done(input string name, input int lim);
        bit seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    // Transaction model: pending bytes of the current message, in the order they must appear.
    typedef struct packed {
        logic       cmd;
        logic [6:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       mq[$];
    logic       e_gnt_a = 1'b0, e_gnt_b = 1'b0, e_done = 1'b0;
    logic [2:0] m_cur = 3'd0;
    logic       m_last_b = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            if (rstb) begin
                mq.delete();
                e_gnt_a = 1'b0; e_gnt_b = 1'b0; e_done = 1'b0;
                m_cur = 3'd0; m_last_b = 1'b1;
                chk("rst_outputs", {gnt_a, gnt_b, done, busy, char_valid, char_is_cmd, cur_msg, rom_addr, char_out}, 32'd0);
            end else begin
                logic idle_now, nd, ga, gb, pick_b;
                logic [2:0] m;
                chk("m_gnt_a", gnt_a, e_gnt_a);
                chk("m_gnt_b", gnt_b, e_gnt_b);
                chk("m_done", done, e_done);
                chk("m_busy", busy, (mq.size() > 0) || e_done);
                chk("m_char_valid", char_valid, mq.size() > 0);
                chk("m_cur_msg", cur_msg, m_cur);
                if (mq.size() > 0) begin
                    chk("m_char_is_cmd", char_is_cmd, mq[0].cmd);
                    chk("m_char_out", char_out, mq[0].data);
                    if (!mq[0].cmd) chk("m_rom_addr", rom_addr, mq[0].addr);
                end
                // Advance using the inputs that the next rising edge will sample.
                idle_now = (mq.size() == 0) && !e_done;
                nd = 1'b0; ga = 1'b0; gb = 1'b0;
                if (mq.size() > 0 && char_ready) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) nd = 1'b1;
                end
                if (idle_now && (req_a || req_b)) begin
                    if (req_a && req_b) pick_b = !m_last_b;
                    else pick_b = req_b;
                    m = pick_b ? msg_b : msg_a;
                    ga = !pick_b; gb = pick_b;
                    if (m == m_cur) begin
                        nd = 1'b1;
                    end else begin
                        mq.push_back('{cmd: 1'b1, addr: 7'd0, data: 8'h01});
                        for (int k = 0; k < 16; k++) begin
                            logic [6:0] a;
                            a = {m, k[3:0]};
                            mq.push_back('{cmd: 1'b0, addr: a, data: rom_mem[a]});
                        end
                    end
                    m_cur = m;
                    m_last_b = pick_b;
                end
                e_done = nd; e_gnt_a = ga; e_gnt_b = gb;
            end
        end
    end

    task automatic do_reset();
        rstb = 1'b1;
        step(); step();
        rstb = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "timeout");
    end

    initial begin
        int g, d, d1, ga1, gb1, nclr;
        bit found, saw_valid;
        logic [6:0] aq[$];

        for (int i = 0; i < 128; i++) rom_mem[i] = 8'(i * 37 + 90);
        rstb = 1'b1; req_a = 1'b0; req_b = 1'b0; msg_a = 3'd0; msg_b = 3'd0; char_ready = 1'b1;
        step(); step();
        chk("reset_gnt_a", gnt_a, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_char_valid", char_valid, 1'b0);
        chk("reset_cur_msg", cur_msg, 3'd0);
        chk("reset_rom_addr", rom_addr, 7'd0);
        chk("reset_char_out", char_out, 8'd0);
        rstb = 1'b0;
        step();

        // Single message 3 at full rate.
        req_a = 1'b1; msg_a = 3'd3;
        g = -1; d = -1; nclr = 0;
        for (int i = 0; i < 40 && d < 0; i++) begin
            step();
            if (gnt_a && g < 0) g = cyc;
            if (char_valid && char_is_cmd) begin
                nclr++;
                chk("t1_clr_byte", char_out, 8'h01);
            end
            if (char_valid && !char_is_cmd) aq.push_back(rom_addr);
            if (done) d = cyc;
        end
        chk("t1_grant_seen", {31'd0, g >= 0}, 32'd1);
        chk("t1_clr_count", nclr, 1);
        chk("t1_grant_to_done_cycles", d - g + 1, 18);
        chk("t1_byte_count", aq.size(), 16);
        for (int k = 0; k < 16 && k < aq.size(); k++) chk("t1_rom_addr_seq", aq[k], 7'h30 + 7'(k));
        chk("t1_cur_msg", cur_msg, 3'd3);
        step();
        chk("t1_done_pulse_len", done, 1'b0);
        chk("t1_idle_after", busy, 1'b0);

        // Both request together: A first, B in the first IDLE after done.
        do_reset();
        req_a = 1'b1; msg_a = 3'd1; req_b = 1'b1; msg_b = 3'd2;
        ga1 = -1; gb1 = -1; d1 = -1;
        for (int i = 0; i < 80 && gb1 < 0; i++) begin
            step();
            if (gnt_a && ga1 < 0) begin
                ga1 = cyc;
                chk("t2_cur_msg_first", cur_msg, 3'd1);
            end
            if (gnt_b && gb1 < 0) gb1 = cyc;
            if (done && d1 < 0) d1 = cyc;
        end
        chk("t2_a_granted", {31'd0, ga1 >= 0}, 32'd1);
        chk("t2_a_before_b", {31'd0, ga1 < gb1}, 32'd1);
        chk("t2_b_after_done", gb1, d1 + 2);
        chk("t2_cur_msg_second", cur_msg, 3'd2);
        wait_done("t2_second_done", 40);

        // Stall at idx 7 of message 5.
        req_a = 1'b1; msg_a = 3'd5;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (char_valid && !char_is_cmd && rom_addr == 7'h57) found = 1'b1;
        end
        chk("t3_reached_idx7", {31'd0, found}, 32'd1);
        char_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_stall_addr", rom_addr, 7'h57);
            chk("t3_stall_char", char_out, rom_mem[7'h57]);
            chk("t3_stall_valid", char_valid, 1'b1);
        end
        char_ready = 1'b1;
        step();
        chk("t3_resume_addr", rom_addr, 7'h58);
        wait_done("t3_done", 30);

        // Repeat of the current message is skipped.
        req_b = 1'b1; msg_b = 3'd4;
        wait_done("t4_first_done", 40);
        step();
        req_b = 1'b1; msg_b = 3'd4;
        step();
        chk("t4_gnt_b", gnt_b, 1'b1);
        chk("t4_done_with_grant", done, 1'b1);
        chk("t4_cur_msg", cur_msg, 3'd4);
        saw_valid = char_valid;
        step();
        chk("t4_done_one_cycle", done, 1'b0);
        for (int i = 0; i < 4; i++) begin
            saw_valid |= char_valid;
            step();
        end
        chk("t4_no_char_valid", {31'd0, saw_valid}, 32'd0);

        // Asynchronous reset in the middle of message 6.
        req_a = 1'b1; msg_a = 3'd6;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (char_valid && !char_is_cmd && rom_addr == 7'h69) found = 1'b1;
        end
        chk("t5_reached_idx9", {31'd0, found}, 32'd1);
        #2;
        rstb = 1'b1;
        #1;
        chk("t5_async_char_valid", char_valid, 1'b0);
        chk("t5_async_busy", busy, 1'b0);
        chk("t5_async_cur_msg", cur_msg, 3'd0);
        chk("t5_async_rom_addr", rom_addr, 7'd0);
        step(); step();
        rstb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_stay_idle", {busy, char_valid, gnt_a, gnt_b}, 4'd0);
        end
        req_a = 1'b1; msg_a = 3'd2; req_b = 1'b1; msg_b = 3'd7;
        step();
        chk("t5_fresh_arb_a", {gnt_a, gnt_b}, 2'b10);
        wait_done("t5_msg_a_done", 40);
        wait_done("t5_msg_b_done", 40);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
